bcla_modadd_pipe: RTL
=====================

BCLA_MODADD_PIPE -- requirements
Module: bcla_modadd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/modulus width in bits (legal 4..64).
REQ-002 SHALL have parameter BLOCK, default 4, carry-lookahead block size in bits; WIDTH SHALL be a multiple of BLOCK.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port p  input  WIDTH  modulus.
REQ-010 SHALL have port op  input  1  0 = modular add, 1 = modular subtract (only with BCLA_MODSUB_EN).
REQ-011 SHALL have port out_valid  output  1  result held on out_sum.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have port out_sum  output  WIDTH  modular result.
REQ-014 SHALL have port out_err  output  1  operand range error for this result.

Function
REQ-015 SHALL accept an operand set when in_valid && in_ready at a rising edge; SHALL deliver one result per accepted set, in order.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers s = a + b (add) or a - b (subtract) as WIDTH+1 bits using block carry-lookahead adders of BLOCK bits; stage 2 registers the corrected result.
REQ-017 Add: out_sum SHALL be s - p if s >= p, else s[WIDTH-1:0].
REQ-018 Subtract: out_sum SHALL be s + p (mod 2^WIDTH) if a < b, else s[WIDTH-1:0].
REQ-019 out_err SHALL be 1 when a >= p, b >= p, or p == 0 at acceptance; out_sum is then a + b (or a - b) truncated to WIDTH, without correction.
REQ-020 Latency SHALL be 2 cycles: set accepted at edge N appears with out_valid=1 after edge N+2 when unstalled.
REQ-021 Each stage SHALL load when empty or when its content moves on the same edge; in_ready = !v1 || (!v2 || out_ready) where v1, v2 are stage valids.
REQ-022 Full throughput: with out_ready held 1, one set SHALL be accepted every cycle.
REQ-023 While out_valid && !out_ready, out_sum/out_err SHALL hold stable; stage 1 SHALL hold once full; in_ready SHALL drop to 0 when both stages are full.
REQ-024 Simultaneous accept at input and drain at output on one edge SHALL both take effect; no set is lost or duplicated.
REQ-025 Carry into the most significant block SHALL wrap cleanly: a=2^WIDTH-4, b=8, p=2^WIDTH-1 SHALL yield 5.

Reset
REQ-026 rst_n low SHALL immediately clear both stage valids: out_valid=0, in_ready=1 while rst_n is low.
REQ-027 out_sum and out_err SHALL reset to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight sets; the first set after rst_n rises follows REQ-020.

Configuration
REQ-029 With BCLA_MODSUB_EN defined, op SHALL select add/subtract per REQ-017/018.
REQ-030 Without BCLA_MODSUB_EN, op SHALL remain a port but be ignored; every set SHALL be a modular add and the subtract correction logic SHALL not be built.

Verification (WIDTH=16, BLOCK=4)
REQ-031 a=126, b=218, p=65521, op=0 -> out_sum=344, out_err=0, two cycles after acceptance.
REQ-032 a=65520, b=8, p=65521, op=0 -> out_sum=7; a=65532, b=8, p=65535 -> out_sum=5.
REQ-033 BCLA_MODSUB_EN: a=5, b=9, p=13, op=1 -> out_sum=9; a=9, b=5, p=13, op=1 -> 4; without macro, a=5, b=9, p=13, op=1 -> 1.
REQ-034 a=20, b=3, p=13 -> out_err=1, out_sum=23; p=0 -> out_err=1.
REQ-035 Four back-to-back sets, out_ready=0 for cycles 2..5 -> in_ready=0 once both stages are full, out_sum stable, all four results in order after out_ready=1, no gaps once streaming.
REQ-036 rst_n pulsed low with two sets in flight -> out_valid=0 at once, neither result ever appears; the next set returns in 2 cycles.

Source files
------------

// File: rtl/bcla_modadd_pipe.sv
// ---------------------------------------------------------------------------
// bcla_modadd_pipe
//   Two-stage pipelined modular adder/subtractor built on block carry-lookahead
//   adders. Stage 1 registers the raw WIDTH+1 bit sum (or difference) plus the
//   modulus and an operand-range error flag. Stage 2 registers the
//   modulus-corrected result.
//
//   Optional feature macro: BCLA_MODSUB_EN
//     defined   : op selects add (0) or subtract (1)
//     undefined : op is ignored, every set is a modular add, and no subtract
//                 correction logic is built
//
// Parameters
//   WIDTH  operand/modulus width (4..64)
//   BLOCK  carry-lookahead block size; WIDTH must be a multiple of BLOCK
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   operand set accepted this cycle
//   a, b       operands
//   p          modulus
//   op         0 = add, 1 = subtract (BCLA_MODSUB_EN only)
//   out_valid  result held on out_sum/out_err
//   out_ready  consumer takes the result this cycle
//   out_sum    modular result
//   out_err    operand range error (a >= p, b >= p or p == 0)
// ---------------------------------------------------------------------------
module bcla_modadd_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_err
);

    localparam int NBLK = WIDTH / BLOCK;

    logic             sub_sel;
    logic [WIDTH:0]   s_next;
    logic             err_next;

    logic             v1;
    logic [WIDTH:0]   s1;
    logic [WIDTH-1:0] p1;
    logic             err1;
    logic             v2;
    logic [WIDTH-1:0] corr;

    logic             load1;
    logic             load2;

`ifdef BCLA_MODSUB_EN
    logic             sub1;
    assign sub_sel = op;
`else
    // op stays on the port but is forced to add; the constant folds away.
    assign sub_sel = op & 1'b0;
`endif

    // Handshake: a stage loads when empty or when its content leaves on
    // the same edge.
    assign load2    = v1 && (!v2 || out_ready);
    assign in_ready = !v1 || (!v2 || out_ready);
    assign load1    = in_valid && in_ready;

    assign out_valid = v2;

    assign err_next = (a >= p) || (b >= p) || (p == '0);

    // Block carry-lookahead adder. Within a block every carry is a flat
    // generate/propagate sum-of-products off the block carry-in; blocks chain
    // through their group generate/propagate. Subtraction is a + ~b + 1.
    always_comb begin : cla_adder
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] gen;
        logic [WIDTH-1:0] prp;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             cj;
        logic             pr;
        logic             blk_g;
        logic             blk_p;

        b_eff = sub_sel ? ~b : b;
        gen   = a & b_eff;
        prp   = a ^ b_eff;
        sum   = '0;
        carry = sub_sel;
        cj    = 1'b0;
        pr    = 1'b1;
        blk_g = 1'b0;
        blk_p = 1'b1;

        for (int blk = 0; blk < NBLK; blk++) begin
            for (int j = 0; j < BLOCK; j++) begin
                cj = 1'b0;
                pr = 1'b1;
                for (int k = j - 1; k >= 0; k--) begin
                    cj = cj | (pr & gen[blk*BLOCK + k]);
                    pr = pr & prp[blk*BLOCK + k];
                end
                cj = cj | (pr & carry);
                sum[blk*BLOCK + j] = prp[blk*BLOCK + j] ^ cj;
            end
            blk_g = 1'b0;
            blk_p = 1'b1;
            for (int k = BLOCK - 1; k >= 0; k--) begin
                blk_g = blk_g | (blk_p & gen[blk*BLOCK + k]);
                blk_p = blk_p & prp[blk*BLOCK + k];
            end
            carry = blk_g | (blk_p & carry);
        end

        // For subtraction the top bit is the borrow (a < b), i.e. not-carry.
        s_next = {carry ^ sub_sel, sum};
    end

    // Stage 2 correction. Error sets pass through uncorrected.
    always_comb begin
        corr = s1[WIDTH-1:0];
        if (!err1) begin
`ifdef BCLA_MODSUB_EN
            if (sub1) begin
                if (s1[WIDTH]) begin
                    corr = s1[WIDTH-1:0] + p1;
                end
            end else if (s1 >= {1'b0, p1}) begin
                corr = s1[WIDTH-1:0] - p1;
            end
`else
            if (s1 >= {1'b0, p1}) begin
                corr = s1[WIDTH-1:0] - p1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1   <= '0;
            p1   <= '0;
            err1 <= 1'b0;
`ifdef BCLA_MODSUB_EN
            sub1 <= 1'b0;
`endif
        end else begin
            if (load1) begin
                v1   <= 1'b1;
                s1   <= s_next;
                p1   <= p;
                err1 <= err_next;
`ifdef BCLA_MODSUB_EN
                sub1 <= sub_sel;
`endif
            end else if (load2) begin
                v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            out_sum <= '0;
            out_err <= 1'b0;
        end else begin
            if (load2) begin
                v2      <= 1'b1;
                out_sum <= corr;
                out_err <= err1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule
